restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 18 +
 rtl/restoring_divider_rca.sv | 31 +++
 rtl/restoring_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared constants for the restoring divider: FSM state encodings and
// the sizing rule for the iteration counter.
package restoring_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   localparam int DEFAULT_NBITS = 8;

   // The counter must be able to hold the values 0..nbits.
   function automatic int cnt_width(input int nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/restoring_divider_rca.sv
// Generic ripple-carry adder. With signd=1 the cout pin reports two's
// complement overflow instead of the unsigned carry out.
module rippleCarryAdder #(
   parameter int Nbits = 8,
   parameter bit signd = 1'b0
) (
   input  logic [Nbits-1:0] a,
   input  logic [Nbits-1:0] b,
   input  logic             cin,
   output logic [Nbits-1:0] sum,
   output logic             cout
);

   logic [Nbits:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < Nbits; gi++) begin : g_fa
         assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
      end

      if (signd) begin : g_ovf
         assign cout = carry[Nbits] ^ carry[Nbits-1];
      end else begin : g_carry
         assign cout = carry[Nbits];
      end
   endgenerate

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first,
// with optional two's complement operands and divide-by-zero reporting.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int Nbits = DEFAULT_NBITS,
   parameter bit signd = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [Nbits-1:0] dividend,
   input  logic [Nbits-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [Nbits-1:0] quotient,
   output logic [Nbits-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(Nbits);

   div_state_t       state_reg;
   logic [Nbits-1:0] dvd_reg;      // dividend magnitude, shifts left as quotient bits enter
   logic [Nbits-1:0] dvs_reg;
   logic [Nbits-1:0] rem_reg;
   logic [Nbits-1:0] raw_dvd_reg;
   logic [CW-1:0]    cnt_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;
   logic             dz_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [Nbits-1:0] quotient_reg;
   logic [Nbits-1:0] remainder_reg;
   logic             div_by_zero_reg;

   logic [Nbits:0]   partial;
   logic [Nbits:0]   divisor_ext;
   logic [Nbits:0]   trial;
   logic             trial_cout;
   logic             borrow;
   logic [Nbits-1:0] dividend_mag;
   logic [Nbits-1:0] divisor_mag;
   logic [Nbits-1:0] q_final;
   logic [Nbits-1:0] r_final;
   logic             unused_bits;

   assign partial     = {rem_reg, dvd_reg[Nbits-1]};
   assign divisor_ext = {1'b0, dvs_reg};

   rippleCarryAdder #(
      .Nbits (Nbits + 1),
      .signd (1'b0)
   ) u_trial_sub (
      .a    (partial),
      .b    (~divisor_ext),
      .cin  (1'b1),
      .sum  (trial),
      .cout (trial_cout)
   );

   assign borrow = ~trial_cout;

   // The top bits are always zero once a step resolves: the remainder is below the divisor.
   assign unused_bits = &{1'b0, trial[Nbits], partial[Nbits]};

   assign dividend_mag = (signd && dividend[Nbits-1]) ? -dividend : dividend;
   assign divisor_mag  = (signd && divisor[Nbits-1])  ? -divisor  : divisor;

   assign q_final = neg_q_reg ? -dvd_reg : dvd_reg;
   assign r_final = neg_r_reg ? -rem_reg : rem_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         dvd_reg         <= '0;
         dvs_reg         <= '0;
         rem_reg         <= '0;
         raw_dvd_reg     <= '0;
         cnt_reg         <= '0;
         neg_q_reg       <= 1'b0;
         neg_r_reg       <= 1'b0;
         dz_reg          <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // busy spans the done pulse, so a start seen during it is ignored
               done_reg <= 1'b0;
               busy_reg <= 1'b0;
               if (start && !busy_reg) begin
                  busy_reg    <= 1'b1;
                  dvd_reg     <= dividend_mag;
                  dvs_reg     <= divisor_mag;
                  raw_dvd_reg <= dividend;
                  rem_reg     <= '0;
                  cnt_reg     <= '0;
                  neg_q_reg   <= signd && (dividend[Nbits-1] ^ divisor[Nbits-1]);
                  neg_r_reg   <= signd && dividend[Nbits-1];
                  dz_reg      <= (divisor == '0);
                  state_reg   <= (divisor == '0) ? ST_DONE : ST_RUN;
               end
            end

            ST_RUN: begin
               dvd_reg <= {dvd_reg[Nbits-2:0], ~borrow};
               rem_reg <= borrow ? partial[Nbits-1:0] : trial[Nbits-1:0];
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(Nbits - 1)) begin
                  state_reg <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (dz_reg) begin
                  quotient_reg    <= '1;
                  remainder_reg   <= raw_dvd_reg;
                  div_by_zero_reg <= 1'b1;
               end else begin
                  quotient_reg    <= q_final;
                  remainder_reg   <= r_final;
                  div_by_zero_reg <= 1'b0;
               end
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = div_by_zero_reg;

endmodule
